// File: rtl/pcs_pkg.sv
// pcs_pkg: constants shared by the PCS blocks (pcs_tx, pcs_rx, gearbox_rx, gearbox_tx).
// Holds the block geometry (sync header + payload), the RX gearbox buffer sizing
// and the two legal sync header encodings.
package pcs_pkg;
    localparam int HEAD_W  = 2;
    localparam int DATA_W  = 64;
    localparam int BLOCK_W = HEAD_W + DATA_W;
    localparam int CNT_W   = 7;
    // Worst case content is 65 leftover bits plus one full incoming word.
    localparam int BUF_W   = BLOCK_W - 1 + DATA_W;
    localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b10;
    localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b01;
endpackage

// File: rtl/gearbox_rx.sv
// gearbox_rx: per-lane RX gearbox turning 64-bit SERDES words into 66-bit blocks.
// Ports:
//   clk      - clock
//   nreset   - synchronous, active-high reset
//   valid_i  - SERDES word valid
//   data_i   - raw SERDES bits, data_i[0] received first
//   slip_i   - drop the oldest bit this cycle (only when valid_i=1)
//   valid_o  - head_o/data_o hold a freshly completed block
//   head_o   - sync header, block bits 1:0
//   data_o   - payload, block bits 65:2
module gearbox_rx
    import pcs_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              slip_i,
    output logic              valid_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o
);
    // Bits above position cnt are kept at zero so the new word can be OR-ed in.
    logic [BUF_W-1:0]  buffer;
    logic [BUF_W-1:0]  buf_s;
    logic [BUF_W-1:0]  merged;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_s;
    logic [CNT_W:0]    fill;
    logic [DATA_W-1:0] word;
    logic              slip;
    logic              drop_new;

    always_comb begin
        slip     = valid_i & slip_i;
        // With an empty buffer the oldest bit is the first bit of the new word.
        drop_new = slip && cnt == '0;
        buf_s    = (slip && !drop_new) ? buffer >> 1 : buffer;
        cnt_s    = (slip && !drop_new) ? cnt - 1'b1 : cnt;
        word     = drop_new ? data_i >> 1 : data_i;
        merged   = buf_s | (BUF_W'(word) << cnt_s);
        fill     = {1'b0, cnt_s} + (CNT_W+1)'(DATA_W) - (CNT_W+1)'(drop_new);
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            buffer  <= '0;
            cnt     <= '0;
            valid_o <= 1'b0;
            head_o  <= '0;
            data_o  <= '0;
        end else if (valid_i && fill >= (CNT_W+1)'(BLOCK_W)) begin
            buffer  <= merged >> BLOCK_W;
            cnt     <= CNT_W'(fill - (CNT_W+1)'(BLOCK_W));
            valid_o <= 1'b1;
            head_o  <= merged[HEAD_W-1:0];
            data_o  <= merged[BLOCK_W-1:HEAD_W];
        end else if (valid_i) begin
            buffer  <= merged;
            cnt     <= CNT_W'(fill);
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
        end
    end

    // Fill can never exceed one bit short of a block once extraction has run.
    always_ff @(posedge clk) begin
        if (!nreset) assert (cnt <= CNT_W'(BLOCK_W - 1));
    end
endmodule

// File: tb/tb_gearbox_rx.sv
// tb_gearbox_rx: randomized self-checking bench for gearbox_rx against a bit-queue model.
module tb_gearbox_rx;
    import pcs_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        valid_i = 1'b0;
    logic        slip_i = 1'b0;
    logic [63:0] data_i = '0;
    logic        valid_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;

    always #5 clk = ~clk;

    gearbox_rx dut (
        .clk(clk), .nreset(nreset), .valid_i(valid_i), .data_i(data_i),
        .slip_i(slip_i), .valid_o(valid_o), .head_o(head_o), .data_o(data_o)
    );

    int checks = 0;
    int errors = 0;
    bit mq[$];
    bit tx[$];
    logic [65:0] src[$];
    logic [65:0] got[$];
    logic        ev = 1'b0;
    logic [1:0]  eh = '0;
    logic [63:0] ed = '0;

    task automatic check(input string tag, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // The model treats the line as one bit stream: append the word, a slip drops the
    // oldest pending bit, and every full 66 bits become the next block.
    task automatic step(input logic r, input logic v, input logic s, input logic [63:0] w);
        logic [65:0] b;
        nreset = r; valid_i = v; slip_i = s; data_i = w;
        @(posedge clk);
        if (r) begin
            mq.delete(); ev = 1'b0; eh = '0; ed = '0;
        end else if (v) begin
            for (int i = 0; i < 64; i++) mq.push_back(w[i]);
            if (s) void'(mq.pop_front());
            ev = mq.size() >= 66;
            if (ev) begin
                for (int i = 0; i < 66; i++) b[i] = mq.pop_front();
                eh = b[1:0]; ed = b[65:2];
            end
        end else begin
            ev = 1'b0;
        end
        @(negedge clk);
        check("valid", 66'(valid_o), 66'(ev));
        check("head", 66'(head_o), 66'(eh));
        check("data", 66'(data_o), 66'(ed));
        check("cnt", 66'(dut.cnt), 66'(mq.size()));
        if (valid_o) got.push_back({data_o, head_o});
    endtask

    task automatic feed(input logic s);
        logic [63:0] w;
        for (int i = 0; i < 64; i++) w[i] = tx.size() > 0 ? tx.pop_front() : 1'($urandom);
        step(1'b0, 1'b1, s, w);
    endtask

    task automatic make(input int garbage, input int n, input bit idx);
        logic [65:0] b;
        src.delete(); tx.delete(); got.delete();
        repeat (garbage) tx.push_back(1'($urandom));
        for (int i = 0; i < n; i++) begin
            b = {idx ? 64'(i) : {$urandom, $urandom}, (i % 2) ? SYNC_DATA : SYNC_CTRL};
            src.push_back(b);
            for (int k = 0; k < 66; k++) tx.push_back(b[k]);
        end
        step(1'b1, 1'b0, 1'b0, '0);
    endtask

    // From observed block index 'from' on, blocks must be consecutive source blocks
    // running through to the last one.
    task automatic match_src(input string tag, input int from);
        int j = -1;
        int k = from;
        while (k < got.size() && j < 0) begin
            foreach (src[i]) if (j < 0 && src[i] === got[k]) j = i;
            k++;
        end
        check({tag, "_found"}, 66'(j >= 0), 66'(1));
        if (j >= 0) begin
            while (k < got.size() && j + 1 < src.size()) begin
                j++;
                check({tag, "_blk"}, got[k], src[j]);
                k++;
            end
            check({tag, "_last"}, 66'(j), 66'(src.size() - 1));
        end
    endtask

    initial begin
        int lows[$];
        int from;
        int first;
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_valid", 66'(valid_o), 66'(0));
        check("rst_data", 66'({data_o, head_o}), 66'(0));

        // aligned stream, payload = block index
        make(0, 64, 1'b1);
        for (int c = 0; c < 66; c++) begin
            feed(1'b0);
            if (!valid_o) lows.push_back(c);
        end
        check("a_count", 66'(got.size()), 66'(64));
        for (int i = 0; i < 64 && i < got.size(); i++) check("a_blk", got[i], src[i]);
        check("a_lows", 66'(lows.size()), 66'(2));
        check("a_low0", 66'(lows.size() > 0 ? lows[0] : -1), 66'(0));
        check("a_low1", 66'(lows.size() > 1 ? lows[1] : -1), 66'(33));

        // one garbage bit removed by a slip on the first word
        make(1, 40, 1'b0);
        feed(1'b1);
        repeat (41) feed(1'b0);
        check("b_count", 66'(got.size()), 66'(40));
        for (int i = 0; i < 40 && i < got.size(); i++) check("b_blk", got[i], src[i]);

        // 37-bit offset removed by 37 slips on separate cycles
        make(37, 40, 1'b0);
        repeat (36) feed(1'b1);
        from = got.size();
        feed(1'b1);
        repeat (5) feed(1'b0);
        match_src("c", from);

        // valid gap with slip requests that must be ignored
        make(0, 30, 1'b0);
        repeat (10) feed(1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        repeat (21) feed(1'b0);
        check("d_count", 66'(got.size()), 66'(30));
        for (int i = 0; i < 30 && i < got.size(); i++) check("d_blk", got[i], src[i]);

        // slip from empty buffer, then a full 66-slip sweep
        make(0, 80, 1'b0);
        feed(1'b1);
        check("e_cnt63", 66'(dut.cnt), 66'(63));
        repeat (64) feed(1'b1);
        from = got.size();
        feed(1'b1);
        repeat (18) feed(1'b0);
        match_src("e", from);

        // reset with 40 bits pending
        make(0, 30, 1'b0);
        for (int i = 0; i < 40 && mq.size() != 40; i++) feed(1'b0);
        check("f_at40", 66'(dut.cnt), 66'(40));
        step(1'b1, 1'b1, 1'b0, {$urandom, $urandom});
        check("f_rst_valid", 66'(valid_o), 66'(0));
        check("f_rst_data", 66'({data_o, head_o}), 66'(0));
        first = -1;
        for (int i = 0; i < 5; i++) begin
            feed(1'b0);
            if (valid_o && first < 0) first = i;
        end
        check("f_first", 66'(first), 66'(1));

        // free-running random traffic
        for (int i = 0; i < 500; i++)
            step($urandom_range(99) == 0, $urandom_range(9) < 8, $urandom_range(9) == 0, {$urandom, $urandom});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gearbox_rx.md
Name: gearbox_rx

Overview:
Per-lane RX gearbox converting the raw 64-bit SERDES word stream into 66-bit blocks (2-bit sync header + 64-bit payload). It sits between the transceiver and pcs_rx, driving serdes_v_i / serdes_head_i / serdes_data_i. It honours pcs_rx's gearbox_slip_o to shift block alignment by one bit during block lock search. The parent instantiates one copy per lane (LANE_N copies in 40GBASE).

Parameters:
HEAD_W, 2, sync header width.
DATA_W, 64, SERDES word width and block payload width.
BLOCK_W, HEAD_W+DATA_W (66), output block width.
CNT_W, 7, width of the buffer fill counter (range 0..65).

Ports:
clk  input  1  clock.
nreset  input  1  reset, synchronous, active-high.
valid_i  input  1  SERDES word valid.
data_i  input  DATA_W  raw SERDES bits; data_i[0] is the earliest received bit.
slip_i  input  1  slip request from pcs_rx; one bit slip per cycle when asserted.
valid_o  output  1  head_o/data_o hold a complete block.
head_o  output  HEAD_W  sync header = block bits 1:0 (bit 0 earliest).
data_o  output  DATA_W  payload = block bits 65:2.

Behaviour:
- Reset (nreset=1 at posedge): fill cnt=0, bit buffer cleared, valid_o=0, head_o=0, data_o=0. Reset mid-stream discards all buffered bits; realignment restarts from the next valid word.
- Internal buffer: 129 bits. Holds cnt unconsumed bits, with the oldest bit at position 0.
- Each cycle with valid_i=1:
  - Step 1 (slip): if slip_i=1, drop the oldest bit. If cnt>0, shift the buffer right by 1 and cnt-=1. If cnt=0, discard data_i[0] instead.
  - Step 2 (append): place the remaining data_i bits at position cnt. New fill f = cnt+64, or f = cnt+63 when a slip occurred.
  - Step 3 (extract): if f>=66, emit bits [65:0] as one block, shift the buffer right by 66, cnt=f-66, valid_o=1 on the next cycle. Otherwise cnt=f, valid_o=0 next cycle.
- Cycle with valid_i=0: no append, no extraction, slip_i ignored. cnt and buffer hold. valid_o=0 next cycle.
- Latency: one register stage. A block completed by the word at cycle N appears on the outputs in cycle N+1.
- head_o/data_o hold their last value when valid_o=0.
- cnt invariant: 0..65 after every cycle. Any other value is a design error (assertion).
- Steady state without slips:
  - From cnt=0, the outputs follow a 33-cycle pattern: 1 cycle with valid_o=0, then 32 cycles with valid_o=1.
  - cnt sequence: 64, 62, 60, ..., 2, 0, then repeats.
- Slip accounting:
  - Each slip removes exactly one bit from the stream.
  - 66 slips advance alignment by exactly one block.
  - A slip on a cycle where f lands at 65 delays the next block by one cycle. This is legal.
- Simultaneous slip_i and extraction in the same cycle: the slip applies before extraction, so the emitted block is already shifted.
- The gearbox performs no header validity checking; pcs_rx handles lock.

Decomposition:
- Shared package pcs_pkg holds HEAD_W, DATA_W, BLOCK_W and the sync header constants SYNC_DATA=2'b10 and SYNC_CTRL=2'b01, for reuse by pcs_tx, pcs_rx and a future gearbox_tx.
- Single module. The barrel-shift append/extract is inline combinational logic; no sub-module is needed.

Test Plan:
- Aligned stream: serialise 64 known 66-bit blocks (headers alternating 01/10, payload = block index) and feed 66 words with valid_i=1, no slip. Required: exactly 64 valid_o pulses with head/data equal to the source in order. valid_o is low in cycles 1 and 34 only.
- Single-bit offset: prepend 1 garbage bit to the stream and pulse slip_i once in cycle 0. Required: all later blocks match the source exactly.
- Slip sweep: on a stream offset by k=37 bits, assert slip_i on 37 separate cycles. Required: output matches the source from the first block extracted after the last slip. pcs_rx achieves lock within 2 alignment markers.
- Valid gaps: deassert valid_i for 3 cycles in mid-stream, with slip_i=1 during the gap. Required: no valid_o during the gap plus one cycle, no bit lost, slip ignored, block order preserved.
- Boundary: drive slip_i=1 with cnt=0. Required: data_i[0] is dropped and cnt becomes 63. The 66-slip sequence yields output identical to the original alignment, shifted by one block.
- Reset mid-operation: assert nreset at cnt=40. Required: next cycle valid_o=0, head_o=0, data_o=0. After release, the first valid_o appears in the 2nd cycle following the first valid word.
